// File: rtl/fpu_int_pkg.sv
// rtl/fpu_int_pkg.sv - shared FP80 constants, operand size codes and packing helper for the integer load path
package fpu_int_pkg;

  localparam logic [14:0] FP80_BIAS       = 15'd16383;
  localparam logic [79:0] FP80_INDEFINITE = 80'hFFFF_C000_0000_0000_0000;

  typedef enum logic [1:0] {
    SZ_W16 = 2'b00,
    SZ_W32 = 2'b01,
    SZ_W64 = 2'b10,
    SZ_BAD = 2'b11
  } int_size_e;

  function automatic logic [79:0] fp80_pack(input logic        sign,
                                            input logic [14:0] exp,
                                            input logic [63:0] mant);
    return {sign, exp, mant};
  endfunction

endpackage

// File: rtl/fpu_lzc64.sv
// rtl/fpu_lzc64.sv - combinational 64-bit leading-zero counter built as a binary merge tree
module fpu_lzc64 (
  input  logic [63:0] a,
  output logic [5:0]  cnt,
  output logic        zero
);

  // Each level merges pairs of nodes: if the upper half is all zero the count
  // is the half-width plus the lower count, otherwise the upper count.
  logic [31:0] z1;
  logic [31:0] c1;
  logic [15:0] z2;
  logic [31:0] c2;
  logic [7:0]  z3;
  logic [23:0] c3;
  logic [3:0]  z4;
  logic [15:0] c4;
  logic [1:0]  z5;
  logic [9:0]  c5;

  for (genvar i = 0; i < 32; i++) begin : g_l1
    assign z1[i] = ~a[2*i+1] & ~a[2*i];
    assign c1[i] = ~a[2*i+1];
  end

  for (genvar i = 0; i < 16; i++) begin : g_l2
    assign z2[i]       = z1[2*i+1] & z1[2*i];
    assign c2[2*i +: 2] = z1[2*i+1] ? {1'b1, c1[2*i]} : {1'b0, c1[2*i+1]};
  end

  for (genvar i = 0; i < 8; i++) begin : g_l3
    assign z3[i]       = z2[2*i+1] & z2[2*i];
    assign c3[3*i +: 3] = z2[2*i+1] ? {1'b1, c2[2*(2*i) +: 2]} : {1'b0, c2[2*(2*i+1) +: 2]};
  end

  for (genvar i = 0; i < 4; i++) begin : g_l4
    assign z4[i]       = z3[2*i+1] & z3[2*i];
    assign c4[4*i +: 4] = z3[2*i+1] ? {1'b1, c3[3*(2*i) +: 3]} : {1'b0, c3[3*(2*i+1) +: 3]};
  end

  for (genvar i = 0; i < 2; i++) begin : g_l5
    assign z5[i]       = z4[2*i+1] & z4[2*i];
    assign c5[5*i +: 5] = z4[2*i+1] ? {1'b1, c4[4*(2*i) +: 4]} : {1'b0, c4[4*(2*i+1) +: 4]};
  end

  assign zero = z5[1] & z5[0];
  assign cnt  = z5[1] ? {1'b1, c5[4:0]} : {1'b0, c5[9:5]};

endmodule

// File: rtl/fpu_int_to_fp80_pipe.sv
// rtl/fpu_int_to_fp80_pipe.sv - three-stage signed integer to FP80 converter for FILD word/dword/qword
module fpu_int_to_fp80_pipe
  import fpu_int_pkg::*;
#(
  parameter int MAX_WIDTH = 64,
  parameter int TAG_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MAX_WIDTH-1:0] int_in,
  input  logic [1:0]           size_in,
  input  logic [TAG_W-1:0]     tag_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [79:0]          fp_out,
  output logic                 invalid_out,
  output logic [TAG_W-1:0]     tag_out
);

  // The whole pipe moves in lockstep; only a held output result stalls it.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic [63:0] in64;
  logic [63:0] ext;
  logic        bad;
  logic        sign_s;
  logic [63:0] mag_s;

  always_comb begin
    in64 = 64'(int_in);
    ext  = '0;
    bad  = 1'b0;
    case (int_size_e'(size_in))
      SZ_W16:  ext = {{48{in64[15]}}, in64[15:0]};
      SZ_W32:  ext = {{32{in64[31]}}, in64[31:0]};
      SZ_W64: begin
        if (MAX_WIDTH >= 64) ext = in64;
        else                 bad = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    sign_s = bad ? 1'b0 : ext[63];
    mag_s  = bad ? 64'd0 : (ext[63] ? (~ext + 64'd1) : ext);
  end

  logic             v1, sign1, inv1;
  logic [63:0]      mag1;
  logic [TAG_W-1:0] tag1;

  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0;
    end else if (adv) begin
      v1 <= in_valid;
      if (in_valid) begin
        sign1 <= sign_s;
        mag1  <= mag_s;
        inv1  <= bad;
        tag1  <= tag_in;
      end
    end
  end

  logic [5:0] lz_s;
  logic       zero_s;

  fpu_lzc64 u_lzc (
    .a    (mag1),
    .cnt  (lz_s),
    .zero (zero_s)
  );

  logic             v2, sign2, inv2, zero2;
  logic [63:0]      mag2;
  logic [5:0]       lz2;
  logic [TAG_W-1:0] tag2;

  always_ff @(posedge clk) begin
    if (reset) begin
      v2 <= 1'b0;
    end else if (adv) begin
      v2 <= v1;
      if (v1) begin
        sign2 <= sign1;
        mag2  <= mag1;
        lz2   <= lz_s;
        zero2 <= zero_s;
        inv2  <= inv1;
        tag2  <= tag1;
      end
    end
  end

  logic [63:0] mant_s;
  logic [14:0] exp_s;
  logic [79:0] res_s;

  always_comb begin
    mant_s = mag2 << lz2;
    exp_s  = FP80_BIAS + 15'd63 - {9'd0, lz2};
    if (inv2)       res_s = FP80_INDEFINITE;
    else if (zero2) res_s = '0;
    else            res_s = fp80_pack(sign2, exp_s, mant_s);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      fp_out      <= '0;
      invalid_out <= 1'b0;
      tag_out     <= '0;
    end else if (adv) begin
      out_valid <= v2;
      if (v2) begin
        fp_out      <= res_s;
        invalid_out <= inv2;
        tag_out     <= tag2;
      end
    end
  end

endmodule

// File: tb/tb_fpu_int_to_fp80_pipe.sv
// tb/tb_fpu_int_to_fp80_pipe.sv - directed bench for the FP80 integer load converter (64- and 32-bit builds)
module tb_fpu_int_to_fp80_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [63:0] int_in = '0;
  logic [1:0]  size_in = 2'b00;
  logic [3:0]  tag_in = '0;

  logic        in_ready, out_valid, invalid_out;
  logic [79:0] fp_out;
  logic [3:0]  tag_out;
  logic        in_ready32, out_valid32, invalid_out32;
  logic [79:0] fp_out32;
  logic [3:0]  tag_out32;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  fpu_int_to_fp80_pipe #(.MAX_WIDTH(64), .TAG_W(4)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .int_in(int_in), .size_in(size_in), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .fp_out(fp_out),
    .invalid_out(invalid_out), .tag_out(tag_out)
  );

  fpu_int_to_fp80_pipe #(.MAX_WIDTH(32), .TAG_W(4)) u_dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready32),
    .int_in(int_in[31:0]), .size_in(size_in), .tag_in(tag_in),
    .out_valid(out_valid32), .out_ready(out_ready), .fp_out(fp_out32),
    .invalid_out(invalid_out32), .tag_out(tag_out32)
  );

  task automatic check(input string name, input logic [79:0] obs, input logic [79:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Called at a negedge; sends one operand and checks latency and the result.
  task automatic run_one(input string name, input logic [1:0] sz, input logic [63:0] d,
                         input logic [3:0] tg, input logic [79:0] efp, input logic ei,
                         input logic [79:0] efp32, input logic ei32);
    int lat;
    in_valid = 1'b1; size_in = sz; int_in = d; tag_in = tg; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    int_in = {$urandom, $urandom};
    size_in = 2'($urandom);
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_lat"}, 80'(lat), 80'd3);
    check({name, "_fp"}, fp_out, efp);
    check({name, "_inv"}, 80'(invalid_out), 80'(ei));
    check({name, "_tag"}, 80'(tag_out), 80'(tg));
    check({name, "_fp32"}, fp_out32, efp32);
    check({name, "_inv32"}, 80'(invalid_out32), 80'(ei32));
  endtask

  localparam logic [79:0] INDEF = 80'hFFFF_C000_0000_0000_0000;

  logic [79:0] bp_exp [6];
  logic [79:0] prev_fp;
  logic [3:0]  prev_tag;
  bit          prev_stall;
  int          sent, got, stalls;

  initial begin
    bp_exp[0] = 80'h3FFF_8000_0000_0000_0000;
    bp_exp[1] = 80'h4000_8000_0000_0000_0000;
    bp_exp[2] = 80'h4000_C000_0000_0000_0000;
    bp_exp[3] = 80'h4001_8000_0000_0000_0000;
    bp_exp[4] = 80'h4001_A000_0000_0000_0000;
    bp_exp[5] = 80'h4001_C000_0000_0000_0000;

    repeat (2) @(negedge clk);
    check("rst_out_valid", 80'(out_valid), 80'd0);
    check("rst_in_ready", 80'(in_ready), 80'd1);
    check("rst_fp_out", fp_out, 80'd0);
    check("rst_invalid", 80'(invalid_out), 80'd0);
    check("rst_tag", 80'(tag_out), 80'd0);
    reset = 1'b0;

    run_one("w16_m1", 2'b00, 64'h0000_0000_0000_FFFF, 4'h1,
            80'hBFFF_8000_0000_0000_0000, 1'b0, 80'hBFFF_8000_0000_0000_0000, 1'b0);
    run_one("w32_max", 2'b01, 64'h0000_0000_7FFF_FFFF, 4'h2,
            80'h401D_FFFF_FFFE_0000_0000, 1'b0, 80'h401D_FFFF_FFFE_0000_0000, 1'b0);
    run_one("w32_zero", 2'b01, 64'h0, 4'h3, 80'h0, 1'b0, 80'h0, 1'b0);
    run_one("w64_min", 2'b10, 64'h8000_0000_0000_0000, 4'h4,
            80'hC03E_8000_0000_0000_0000, 1'b0, INDEF, 1'b1);
    run_one("w16_upper", 2'b00, 64'hDEAD_BEEF_0000_0005, 4'h5,
            80'h4001_A000_0000_0000_0000, 1'b0, 80'h4001_A000_0000_0000_0000, 1'b0);
    run_one("bad_size", 2'b11, 64'h1234_5678_9ABC_DEF0, 4'hA, INDEF, 1'b1, INDEF, 1'b1);
    run_one("w32_min", 2'b01, 64'h0000_0000_8000_0000, 4'h6,
            80'hC01E_8000_0000_0000_0000, 1'b0, 80'hC01E_8000_0000_0000_0000, 1'b0);
    run_one("w16_min", 2'b00, 64'h0000_0000_0000_8000, 4'h7,
            80'hC00E_8000_0000_0000_0000, 1'b0, 80'hC00E_8000_0000_0000_0000, 1'b0);
    run_one("w64_max", 2'b10, 64'h7FFF_FFFF_FFFF_FFFF, 4'h8,
            80'h403D_FFFF_FFFF_FFFF_FFFE, 1'b0, INDEF, 1'b1);
    run_one("w16_one", 2'b00, 64'h0000_0000_0000_0001, 4'h9,
            80'h3FFF_8000_0000_0000_0000, 1'b0, 80'h3FFF_8000_0000_0000_0000, 1'b0);

    // Backpressure: six back-to-back operands, consumer stalls for cycles 4..9.
    sent = 0; got = 0; stalls = 0; prev_stall = 1'b0;
    prev_fp = '0; prev_tag = '0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (prev_stall) begin
        check("bp_hold_fp", fp_out, prev_fp);
        check("bp_hold_tag", 80'(tag_out), 80'(prev_tag));
      end
      out_ready = !(c >= 4 && c <= 9);
      in_valid = (sent < 6);
      size_in = 2'b00;
      int_in = 64'(sent + 1);
      tag_in = 4'(sent);
      #1;
      if (out_valid && !out_ready) begin
        stalls++;
        check("bp_in_ready", 80'(in_ready), 80'd0);
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        if (got < 6) begin
          check("bp_tag", 80'(tag_out), 80'(got));
          check("bp_fp", fp_out, bp_exp[got]);
        end else begin
          check("bp_extra", 80'(got), 80'd5);
        end
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_fp = fp_out;
      prev_tag = tag_out;
    end
    check("bp_sent", 80'(sent), 80'd6);
    check("bp_got", 80'(got), 80'd6);
    check("bp_stalls", 80'(stalls), 80'd6);

    // Reset with two operands in flight, then a fresh operand.
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; size_in = 2'b00; int_in = 64'h2; tag_in = 4'hB;
    @(negedge clk);
    int_in = 64'h3; tag_in = 4'hC;
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_valid", 80'(out_valid), 80'd0);
    check("mid_rst_fp", fp_out, 80'd0);
    run_one("post_rst", 2'b01, 64'h0000_0000_FFFF_FFFE, 4'hD,
            80'hC000_8000_0000_0000_0000, 1'b0, 80'hC000_8000_0000_0000_0000, 1'b0);
    @(negedge clk);
    check("post_rst_drain", 80'(out_valid), 80'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fpu_int_to_fp80_pipe.md
# fpu_int_to_fp80_pipe

Pipelined signed-integer to 80-bit extended-precision converter for the FPU8087 load path: FILD word, dword and qword.
- Accepts a 16-, 32- or 64-bit two's-complement operand, selected per transaction.
- Produces exactly rounded FP80 results; every integer up to 64 bits fits the 64-bit significand, so no rounding step exists.
- Three-stage pipeline with a valid/ready handshake and one result per cycle.
- Replaces the single-width, single-cycle converter in the microcode load datapath.

## Interface
- MAX_WIDTH, 64, widest supported operand: 32 or 64. With 32, size 2'b10 is invalid.
- TAG_W, 4, width of the opaque tag carried alongside each operand.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; clears all valid flags.
- in_valid  in  1  operand present.
- in_ready  out  1  converter can accept this cycle.
- int_in  in  MAX_WIDTH  operand, right-aligned. Bits above the selected size are ignored.
- size_in  in  2  operand size: 00=16, 01=32, 10=64, 11=invalid.
- tag_in  in  TAG_W  passed through unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- fp_out  out  80  {sign, exp[14:0], mant[63:0]}, explicit integer bit.
- invalid_out  out  1  size was invalid, or unsupported for this MAX_WIDTH.
- tag_out  out  TAG_W  tag of this result.

## Operation
- Handshake: a transfer occurs on any clk edge where valid && ready on that side.
- Pipeline stall rule: adv = !out_valid || out_ready; in_ready = adv. All three stages advance together when adv is high.
- S1, size/sign:
  - Sign-extend int_in from the selected size to 64 bits.
  - sign = bit 63 of the extended value; abs = sign ? -x : x, computed as 64-bit unsigned.
  - -2^63 yields abs = 2^63, which is correct.
  - Invalid size: set the inv flag and force abs = 0.
- S2, normalize count: lz = leading-zero count of abs, 0..63; zero flag = (abs == 0).
- S3, shift/pack:
  - mant = abs << lz; exp = 16383 + 63 - lz.
  - Zero: fp_out = 80'h0, i.e. +0. Negative zero cannot occur.
  - Invalid: fp_out = 80'hFFFF_C000_0000_0000_0000 (real indefinite) and invalid_out = 1.
  - Otherwise invalid_out = 0.
- tag and inv travel with their data through every stage.
- Widths: exp is 15 bits, and its maximum of 16446 (0x403E) never overflows. lz is 6 bits.

## Timing
- Latency: exactly 3 cycles from the accepting edge to out_valid high when unstalled. Throughput is 1 per cycle.
- While out_valid && !out_ready:
  - fp_out, invalid_out and tag_out hold stable.
  - in_ready = 0; no stage updates.
- Simultaneous accept on input and output in the same cycle is legal and loses no beat.
- Reset values: out_valid = 0, in_ready = 1 (follows adv), fp_out = 0, invalid_out = 0, tag_out = 0. All internal stage valid flags = 0.
- Reset mid-flight: every in-flight operand is discarded with no output produced. The first accept after reset is a normal 3-cycle transaction.
- Inputs are sampled only when in_valid && in_ready. int_in may change at any other time.
- No combinational path from in_valid to out_valid. in_ready depends combinationally on out_ready only.

## Structure
- Package fpu_int_pkg:
  - FP80_BIAS = 15'd16383.
  - Size encodings SZ_W16/SZ_W32/SZ_W64/SZ_BAD.
  - FP80_INDEFINITE.
  - Function fp80_pack(sign, exp, mant).
- Sub-module fpu_lzc64: combinational 64-bit leading-zero counter.
  - Output: 6-bit count plus an all-zero flag.
  - Tree structure; instantiated in S2.
  - Reused later by the FP80 normalizer.
- Top module holds the three stage registers and the stall logic. No FSM beyond the per-stage valid bits.

## Test plan
- size 00, int_in = 0xFFFF, out_ready = 1 -> after 3 cycles fp_out = 0xBFFF_8000000000000000, invalid_out = 0.
- size 01, int_in = 0x7FFFFFFF -> 0x401D_FFFFFFFE00000000. Size 01, int_in = 0 -> 80'h0.
- size 10, int_in = 0x8000000000000000 -> 0xC03E_8000000000000000. Size 00, int_in = 0xDEADBEEF00000005 -> 0x4001_A000000000000000 (upper bits ignored).
- size 11, tag 0xA -> fp_out = 0xFFFF_C000000000000000, invalid_out = 1, tag_out = 0xA. With MAX_WIDTH = 32, size 10 gives the same response.
- Backpressure:
  - Stimulus: 6 back-to-back operands with tags 0..5; out_ready low for cycles 4-9, then high.
  - in_ready drops during the stall; no result lost or duplicated.
  - Tags emerge 0..5 in order; outputs stay stable while stalled.
- Reset asserted for 1 cycle with 2 operands in flight -> out_valid stays 0 for those operands. A new operand accepted next cycle emerges 3 cycles later.
